// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div -- sequential restoring divider, signed or unsigned, one quotient bit
// per clock.
//
// A request is accepted on the clock edge that sees start=1 while idle. The
// operands are converted to magnitudes and divided MSB-first over WIDTH
// edges. One final edge applies the sign correction and loads the result
// registers. Division by zero skips the iteration entirely.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   request a division (ignored unless idle)
//   sgn       in   1 = signed two's-complement, 0 = unsigned
//   S         in   dividend, captured on the accepting edge
//   T         in   divisor, captured on the accepting edge
//   quot      out  registered quotient
//   rem       out  registered remainder
//   busy      out  high while an operation is in progress
//   done      out  one-cycle pulse when quot/rem/div_zero are updated
//   div_zero  out  last completed operation had a zero divisor
// -----------------------------------------------------------------------------
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Two's-complement negation at the operand width.
  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    neg2c = {WIDTH{1'b0}} - x;
  endfunction

  // Magnitude of an operand: negate only when signed and the MSB is set.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic             is_signed);
    if (is_signed && x[WIDTH-1]) begin
      mag = neg2c(x);
    end else begin
      mag = x;
    end
  endfunction

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] dvd_q,     dvd_d;     // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] dvs_q,     dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] part_q,    part_d;    // restored partial remainder
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             negq_q,    negq_d;    // signs of S and T differ
  logic             negr_q,    negr_d;    // dividend was negative
  logic             dz_q,      dz_d;      // current operation has T == 0
  logic [WIDTH-1:0] quot_q,    quot_d;
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             divz_q,    divz_d;

  // Working partial remainder is WIDTH+1 bits wide: the shifted-in value can
  // reach 2*divisor-1, so the extra bit is needed before the trial subtract.
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic             fits_s;

  // Trial subtraction for one restoring-division step.
  always_comb begin
    shifted_s = {part_q, dvd_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dvs_q};
    fits_s    = ~trial_s[WIDTH];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    divz_d  = divz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dvs_d  = mag(T, sgn);
          part_d = {WIDTH{1'b0}};
          cnt_d  = CNT_LAST;
          negq_d = sgn & (S[WIDTH-1] ^ T[WIDTH-1]);
          negr_d = sgn & S[WIDTH-1];
          if (T == {WIDTH{1'b0}}) begin
            // Keep the raw dividend: it is returned unmodified as remainder.
            dz_d    = 1'b1;
            dvd_d   = S;
            state_d = ST_FIX;
          end else begin
            dz_d    = 1'b0;
            dvd_d   = mag(S, sgn);
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        // Quotient bits shift into the vacated LSBs of the dividend register.
        dvd_d = {dvd_q[WIDTH-2:0], fits_s};
        if (fits_s) begin
          part_d = trial_s[WIDTH-1:0];
        end else begin
          part_d = shifted_s[WIDTH-1:0];
        end
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_FIX;
        end else begin
          cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          state_d = ST_CALC;
        end
      end

      ST_FIX: begin
        if (dz_q) begin
          quot_d = {WIDTH{1'b1}};
          rem_d  = dvd_q;
          divz_d = 1'b1;
        end else begin
          // Most-negative / -1 lands here with magnitude 2^(WIDTH-1) and no
          // negation, which already reads back as the most-negative value.
          if (negq_q) begin
            quot_d = neg2c(dvd_q);
          end else begin
            quot_d = dvd_q;
          end
          if (negr_q) begin
            rem_d = neg2c(part_q);
          end else begin
            rem_d = part_q;
          end
          divz_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dvd_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      part_q  <= {WIDTH{1'b0}};
      cnt_q   <= CNT_ZERO;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = divz_q;

endmodule
